// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared types and constants for the AXI-Stream frame generator
// Purpose: FSM state encoding plus PRBS-31 seed, tap positions and single-step helper.
// Ports: none (package).
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_e;

    localparam int                   PRBS_WIDTH  = 31;
    localparam logic [PRBS_WIDTH-1:0] PRBS_SEED  = 31'h7FFF_FFFF;
    // x^31 + x^28 + 1 : feedback from stages 31 and 28 (bit indices 30 and 27)
    localparam int                   PRBS_TAP_HI = 30;
    localparam int                   PRBS_TAP_LO = 27;

    function automatic logic [PRBS_WIDTH-1:0] prbs31_step(input logic [PRBS_WIDTH-1:0] s);
        return {s[PRBS_WIDTH-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/axis_prbs_lfsr.sv
// rtl/axis_prbs_lfsr.sv - parallel PRBS-31 LFSR advance by STEPS bits
// Purpose: combinational next-state of a Fibonacci PRBS-31 after STEPS shifts.
// Ports:
//   state_i  in   31  current LFSR state
//   state_o  out  31  state after STEPS single-bit steps
module axis_prbs_lfsr
    import axis_gen_pkg::*;
#(
    parameter int STEPS = 32
) (
    input  logic [PRBS_WIDTH-1:0] state_i,
    output logic [PRBS_WIDTH-1:0] state_o
);

    // Unrolled at elaboration into a pure XOR network.
    always_comb begin
        state_o = state_i;
        for (int i = 0; i < STEPS; i++) begin
            state_o = prbs31_step(state_o);
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI-Stream master emitting framed counter (or PRBS) data
// Purpose: start/stop controlled frame source with tlast, configurable frame length,
//   frame count per run and inter-frame gap. Define AXIS_FRAME_GEN_PRBS_EN to replace
//   the counter payload with PRBS-31 words.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   start, stop              1-cycle control pulses
//   frame_len, num_frames    beats per frame (0 -> 1), frames per run (0 -> unlimited)
//   gap_len                  idle cycles after each non-final tlast beat
//   m_axis_t*                AXI-Stream master interface
//   busy                     run in progress
//   frame_cnt                frames completed since last start (saturating)
module axis_frame_gen
    import axis_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [LEN_WIDTH-1:0]  num_frames,
    input  logic [GAP_WIDTH-1:0]  gap_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           frame_cnt
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = 1;
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;

    gen_state_e             state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   nfr_q, nfr_d;
    logic [LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [GAP_WIDTH-1:0]   gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   stop_q, stop_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;

    logic                   run_start;
    logic                   accept;
    logic                   last_accept;
    logic                   final_frame;
    logic                   run_end;
    logic [LEN_WIDTH-1:0]   start_len;
    logic [DATA_WIDTH-1:0]  start_data;
    logic [DATA_WIDTH-1:0]  next_data;

    // stop wins over a simultaneous start
    assign run_start   = (state_q == IDLE) && start && !stop;
    assign accept      = tvalid_q && m_axis_tready;
    assign last_accept = accept && tlast_q;
    assign start_len   = (frame_len == '0) ? LEN_ONE : frame_len;
    // frame_cnt_q still holds the count before this tlast is retired
    assign final_frame = (nfr_q != '0) && (frame_cnt_q == (32'(nfr_q) - 32'd1));
    // a stop arriving on the tlast beat itself also ends the run there
    assign run_end     = last_accept && (final_frame || stop_q || stop);

`ifdef AXIS_FRAME_GEN_PRBS_EN
    logic [PRBS_WIDTH-1:0]            lfsr_q, lfsr_d, lfsr_next;
    logic [DATA_WIDTH+PRBS_WIDTH-1:0] seed_wide, next_wide;

    axis_prbs_lfsr #(
        .STEPS (DATA_WIDTH)
    ) u_prbs (
        .state_i (lfsr_q),
        .state_o (lfsr_next)
    );

    // zero-extend or truncate the 31-bit state onto the data bus
    always_comb begin
        seed_wide  = {{DATA_WIDTH{1'b0}}, PRBS_SEED};
        next_wide  = {{DATA_WIDTH{1'b0}}, lfsr_next};
        start_data = seed_wide[DATA_WIDTH-1:0];
        next_data  = next_wide[DATA_WIDTH-1:0];
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (run_start) begin
            lfsr_d = PRBS_SEED;
        end else if (accept) begin
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        start_data = '0;
        next_data  = tdata_q + DATA_ONE;
    end
`endif

    // state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            len_q       <= LEN_ONE;
            nfr_q       <= '0;
            beat_q      <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            stop_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nfr_q       <= nfr_d;
            beat_q      <= beat_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_q      <= stop_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run_start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_accept) begin
                    if (run_end) begin
                        state_d = IDLE;
                    end else if (gap_len_q != '0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (gap_cnt_q <= GAP_ONE) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // registered-output / datapath next values
    always_comb begin
        len_d       = len_q;
        nfr_d       = nfr_q;
        beat_d      = beat_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        stop_d      = stop_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (run_start) begin
                    len_d       = start_len;
                    nfr_d       = num_frames;
                    gap_len_d   = gap_len;
                    beat_d      = '0;
                    tvalid_d    = 1'b1;
                    tlast_d     = (start_len == LEN_ONE);
                    tdata_d     = start_data;
                    frame_cnt_d = '0;
                end
            end
            SEND: begin
                stop_d = stop_q || stop;
                if (accept) begin
                    tdata_d = next_data;
                    if (tlast_q) begin
                        frame_cnt_d = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 32'd1;
                        beat_d      = '0;
                        if (run_end || (gap_len_q != '0)) begin
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_len_q;
                        end else begin
                            tlast_d = (len_q == LEN_ONE);
                        end
                    end else begin
                        beat_d  = beat_q + LEN_ONE;
                        tlast_d = ((beat_q + LEN_ONE) == (len_q - LEN_ONE));
                    end
                end
            end
            GAP: begin
                stop_d = stop_q || stop;
                if (!stop) begin
                    if (gap_cnt_q <= GAP_ONE) begin
                        tvalid_d = 1'b1;
                        beat_d   = '0;
                        tlast_d  = (len_q == LEN_ONE);
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != IDLE);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - self-checking bench for axis_frame_gen
module tb_axis_frame_gen;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [15:0] frame_len;
    logic [15:0] num_frames;
    logic [7:0]  gap_len;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [31:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    axis_frame_gen #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .GAP_WIDTH  (8)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .stop          (stop),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .gap_len       (gap_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Beats of a run are numbered globally from 0; beat n carries data n and is
    // the last of its frame when n mod len == len-1.
    bit armed  = 0;
    bit m_busy = 0, m_valid = 0, m_stop = 0, m_rst = 0;
    int m_n = 0, m_len = 1, m_nfr = 0, m_gap = 0, m_gap_left = 0, m_fc = 0;

    always @(posedge aclk) begin
        if (!aresetn) begin
            armed = 1; m_busy = 0; m_valid = 0; m_fc = 0; m_rst = 1; m_n = 0; m_stop = 0;
        end else if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1; m_valid = 1; m_n = 0; m_fc = 0; m_rst = 0; m_stop = 0;
                m_len = (frame_len == 0) ? 1 : int'(frame_len);
                m_nfr = int'(num_frames);
                m_gap = int'(gap_len);
            end
        end else if (m_valid) begin
            if (stop) m_stop = 1;
            if (m_axis_tready) begin
                if (m_n % m_len == m_len - 1) begin
                    m_fc++;
                    if ((m_nfr != 0 && m_fc == m_nfr) || m_stop) begin
                        m_busy = 0; m_valid = 0;
                    end else if (m_gap != 0) begin
                        m_valid = 0; m_gap_left = m_gap;
                    end
                end
                m_n++;
            end
        end else begin
            if (stop) begin
                m_busy = 0;
            end else begin
                m_gap_left--;
                if (m_gap_left == 0) m_valid = 1;
            end
        end
    end

    // ---------------- compare process + beat log ----------------
    logic [31:0] acc_data[$];
    bit          acc_last[$];
    int          idle_cnt  = 0;
    int          valid_cnt = 0;

    always @(negedge aclk) begin
        if (armed) begin
            chk("tvalid", 32'(m_axis_tvalid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("frame_cnt", frame_cnt, 32'(m_fc));
            if (m_valid) begin
                chk("tdata", m_axis_tdata, 32'(m_n));
                chk("tlast", 32'(m_axis_tlast), 32'(m_n % m_len == m_len - 1));
            end else if (m_rst) begin
                chk("rst_tdata", m_axis_tdata, 32'd0);
                chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
            end
        end
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            acc_data.push_back(m_axis_tdata);
            acc_last.push_back(m_axis_tlast);
        end
        if (aresetn && busy && !m_axis_tvalid) idle_cnt++;
        if (aresetn && m_axis_tvalid) valid_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_last.delete();
        idle_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic start_run(input int fl, input int nf, input int gp);
        frame_len  = 16'(fl);
        num_frames = 16'(nf);
        gap_len    = 8'(gp);
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            cyc();
            c++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", nm, busy, budget);
        end
    endtask

    initial begin
        int fl, nf, gp, cn;
        aresetn = 1'b0; start = 1'b0; stop = 1'b0;
        frame_len = '0; num_frames = '0; gap_len = '0; m_axis_tready = 1'b1;
        repeat (3) cyc();
        aresetn = 1'b1;
        cyc();
        chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_cnt", frame_cnt, 32'd0);

        // 1: two back-to-back frames of 4
        clear_log();
        start_run(4, 2, 0);
        wait_idle("t1", 100);
        chk("t1_beats", 32'(acc_data.size()), 32'd8);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk("t1_data", acc_data[i], 32'(i));
            chk("t1_last", 32'(acc_last[i]), 32'(i == 3 || i == 7));
        end
        chk("t1_valid_cycles", 32'(valid_cnt), 32'd8);
        chk("t1_frame_cnt", frame_cnt, 32'd2);

        // 2: backpressure during the first three cycles of the run
        clear_log();
        m_axis_tready = 1'b0;
        start_run(3, 1, 0);
        repeat (3) cyc();
        m_axis_tready = 1'b1;
        wait_idle("t2", 100);
        chk("t2_beats", 32'(acc_data.size()), 32'd3);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk("t2_data", acc_data[i], 32'(i));
            chk("t2_last", 32'(acc_last[i]), 32'(i == 2));
        end
        chk("t2_valid_cycles", 32'(valid_cnt), 32'd6);

        // 3: gap of 5 between frames, none after the last
        clear_log();
        start_run(2, 3, 5);
        wait_idle("t3", 200);
        chk("t3_beats", 32'(acc_data.size()), 32'd6);
        chk("t3_gap_cycles", 32'(idle_cnt), 32'd10);
        chk("t3_frame_cnt", frame_cnt, 32'd3);

        // 4: unlimited run, stop on beat 1 of frame 2
        clear_log();
        start_run(4, 0, 0);
        repeat (5) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_idle("t4", 100);
        chk("t4_beats", 32'(acc_data.size()), 32'd8);
        if (acc_data.size() == 8) begin
            chk("t4_last_data", acc_data[7], 32'd7);
            chk("t4_last_flag", 32'(acc_last[7]), 32'd1);
        end
        chk("t4_frame_cnt", frame_cnt, 32'd2);

        // 5: frame_len 0 behaves as 1; start while busy ignored
        clear_log();
        start_run(0, 3, 0);
        start_run(5, 1, 2);
        wait_idle("t5", 100);
        chk("t5_beats", 32'(acc_data.size()), 32'd3);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk("t5_data", acc_data[i], 32'(i));
            chk("t5_last", 32'(acc_last[i]), 32'd1);
        end
        chk("t5_frame_cnt", frame_cnt, 32'd3);

        // 6: reset mid-frame, then restart from 0
        start_run(4, 0, 0);
        repeat (6) cyc();
        aresetn = 1'b0;
        cyc();
        chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_frame_cnt", frame_cnt, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        aresetn = 1'b1;
        cyc();
        clear_log();
        start_run(2, 1, 0);
        wait_idle("t6", 100);
        chk("t6_beats", 32'(acc_data.size()), 32'd2);
        if (acc_data.size() > 0) chk("t6_first_data", acc_data[0], 32'd0);

        // 7: stop together with start in IDLE
        start = 1'b1; stop = 1'b1; frame_len = 16'd3; num_frames = 16'd1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t7_not_started", 32'(busy), 32'd0);

        // randomized runs, checked every cycle by the model
        for (int r = 0; r < 40; r++) begin
            fl = int'($urandom_range(0, 5));
            nf = int'($urandom_range(0, 3));
            gp = int'($urandom_range(0, 3));
            cn = 0;
            frame_len  = 16'(fl);
            num_frames = 16'(nf);
            gap_len    = 8'(gp);
            start      = 1'b1;
            stop       = ($urandom_range(0, 9) == 0);
            cyc();
            start = 1'b0;
            stop  = 1'b0;
            while (busy && cn < 600) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                stop          = ($urandom_range(0, 49) == 0) || (nf == 0 && cn > 40);
                start         = ($urandom_range(0, 19) == 0);
                frame_len     = 16'($urandom_range(0, 5));
                gap_len       = 8'($urandom_range(0, 3));
                cyc();
                cn++;
            end
            start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL rand_timeout: busy %0b after %0d cycles, required 0", busy, cn);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
